fpu_wb_buffer: RTL

FPU_WB_BUFFER -- requirements
Module: fpu_wb_buffer

---
 rtl/fpu_wb_buffer.sv | 118 +++++++++++
 1 files changed

// File: rtl/fpu_wb_buffer.sv
// Writeback FIFO between the FPU and the register file, with sticky fflags accumulation.
// Define FPU_WB_BYPASS_EN to let a result reach writeback in the same cycle when the FIFO is empty.
module fpu_wb_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [63:0]              fpu_result_i,
  input  logic [4:0]               fpu_status_i,
  input  logic                     fpu_tag_i,
  input  logic                     fpu_valid_i,
  output logic                     fpu_ready_o,
  input  logic                     flush_i,
  output logic [63:0]              wb_result_o,
  output logic [4:0]               wb_status_o,
  output logic                     wb_tag_o,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [4:0]               fflags_o,
  input  logic                     fflags_clr_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  status;
    logic        tag;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [4:0]      fflags_q;

  entry_t          in_entry, head_entry, out_entry;
  logic            empty, full;
  logic            bypass, push, pop;
  logic [4:0]      retired_status;

  assign in_entry   = '{result: fpu_result_i, status: fpu_status_i, tag: fpu_tag_i};
  assign head_entry = mem_q[rd_ptr_q];
  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));

  // Ready depends only on the registered occupancy, so the FPU never sees wb_ready_i.
  assign fpu_ready_o = !full;

`ifdef FPU_WB_BYPASS_EN
  // rst_ni gates the bypass so wb_valid_o holds its reset value while reset is asserted.
  assign bypass = rst_ni && empty && fpu_valid_i && wb_ready_i && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  assign push = fpu_valid_i && fpu_ready_o && !flush_i && !bypass;
  assign pop  = !empty && wb_ready_i && !flush_i;

  // NOTE: every signal driven from always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    out_entry      = head_entry;
    retired_status = '0;
    if (bypass) begin
      out_entry      = in_entry;
      retired_status = fpu_status_i;
    end else if (pop) begin
      retired_status = head_entry.status;
    end
  end

  assign wb_result_o = out_entry.result;
  assign wb_status_o = out_entry.status;
  assign wb_tag_o    = out_entry.tag;
  assign wb_valid_o  = !empty || bypass;
  assign fflags_o    = fflags_q;
  assign count_o     = count_q;

  // NOTE: state registers use non-blocking assignments so all flops sample the pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  // Clear takes priority over the old value but not over the status retiring this cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fflags_q <= '0;
    end else if (fflags_clr_i) begin
      fflags_q <= retired_status;
    end else begin
      fflags_q <= fflags_q | retired_status;
    end
  end

  // NOTE: payload storage is deliberately not reset; valid state lives in count/pointers only.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= CW'(DEPTH));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop && empty));

endmodule
